// File: rtl/cam_pkg.sv
// Shared types and constants for the CAM subarray command sequencer.
package cam_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LEN_W    = 5;
    localparam int unsigned CMP_ROWS = 32;
    localparam int unsigned PPG_ROWS = 8;
    localparam int unsigned CMP_AW   = $clog2(CMP_ROWS);
    localparam int unsigned PPG_AW   = $clog2(PPG_ROWS);

    localparam logic [1:0] OP_WRITE    = 2'd0;
    localparam logic [1:0] OP_SEARCH   = 2'd1;
    localparam logic [1:0] OP_SRCH_UPD = 2'd2;
    localparam logic [1:0] OP_MASK_UPD = 2'd3;

    localparam logic [2:0] MODE_WRITE = 3'b000;
    localparam logic [2:0] MODE_UPD   = 3'b001;
    localparam logic [2:0] MODE_CMP1  = 3'b010;
    localparam logic [2:0] MODE_PPG1  = 3'b011;
    localparam logic [2:0] MODE_CMP2  = 3'b100;
    localparam logic [2:0] MODE_PPG2  = 3'b101;
    localparam logic [2:0] MODE_MIX   = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR, ST_CMP, ST_CAP, ST_UPD, ST_RSP
    } state_e;

    typedef struct packed {
        logic [1:0]          op;
        logic [2:0]          search_mode;
        logic [2*CMP_AW-1:0] cmp_addr;
        logic [2*PPG_AW-1:0] ppg_addr;
        logic [1:0]          cmp_data;
        logic [1:0]          ppg_data;
        logic                addr_sel;
        logic [CMP_AW-1:0]   dst_row;
        logic [DATA_W-1:0]   wdata;
        logic                upd_val;
        logic [LEN_W-1:0]    len;
    } cmd_t;

    typedef struct packed {
        logic                ce;
        logic [2:0]          mode;
        logic [DATA_W-1:0]   data_in;
        logic                update_signal;
        logic [2*CMP_AW-1:0] cmp_addr;
        logic [2*PPG_AW-1:0] ppg_addr;
        logic [1:0]          cmp_data;
        logic [1:0]          ppg_data;
        logic [DATA_W-1:0]   tag_in;
        logic                addr_select;
    } cam_pins_t;

    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode >= MODE_CMP1) && (mode <= MODE_MIX);
    endfunction

endpackage

// File: rtl/cam_subarray_seq_if.sv
// Command and response handshake bundle between scheduler and sequencer.
interface cam_subarray_seq_if;
    import cam_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [2:0]          cmd_search_mode;
    logic [2*CMP_AW-1:0] cmd_cmp_addr;
    logic [2*PPG_AW-1:0] cmd_ppg_addr;
    logic [1:0]          cmd_cmp_data;
    logic [1:0]          cmd_ppg_data;
    logic                cmd_addr_sel;
    logic [CMP_AW-1:0]   cmd_dst_row;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                cmd_upd_val;
    logic [LEN_W-1:0]    cmd_len;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_tag;
    logic                rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_search_mode, cmd_cmp_addr, cmd_ppg_addr,
               cmd_cmp_data, cmd_ppg_data, cmd_addr_sel, cmd_dst_row, cmd_wdata,
               cmd_upd_val, cmd_len, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tag, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_search_mode, cmd_cmp_addr, cmd_ppg_addr,
               cmd_cmp_data, cmd_ppg_data, cmd_addr_sel, cmd_dst_row, cmd_wdata,
               cmd_upd_val, cmd_len, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tag, rsp_err
    );

endinterface

// File: rtl/cam_seq_addr_gen.sv
// Per-iteration row addresses: sweep compare pairs and the write/update target.
module cam_seq_addr_gen
    import cam_pkg::*;
(
    input  cmd_t                cmd_i,
    input  logic [LEN_W-1:0]    iter_i,
    output logic [2*CMP_AW-1:0] cmp_addr_o,
    output logic [2*PPG_AW-1:0] ppg_addr_o,
    output logic [2*CMP_AW-1:0] tgt_cmp_addr_o,
    output logic [2*PPG_AW-1:0] tgt_ppg_addr_o
);

    logic [CMP_AW-1:0] cmp_step;
    logic [PPG_AW-1:0] ppg_step;

    assign cmp_step = CMP_AW'(iter_i);
    assign ppg_step = PPG_AW'(iter_i);

    // Each half of a row pair advances independently and wraps within its region.
    assign cmp_addr_o = {CMP_AW'(cmd_i.cmp_addr[2*CMP_AW-1:CMP_AW] + cmp_step),
                         CMP_AW'(cmd_i.cmp_addr[CMP_AW-1:0] + cmp_step)};
    assign ppg_addr_o = {PPG_AW'(cmd_i.ppg_addr[2*PPG_AW-1:PPG_AW] + ppg_step),
                         PPG_AW'(cmd_i.ppg_addr[PPG_AW-1:0] + ppg_step)};

    always_comb begin
        tgt_cmp_addr_o = '0;
        tgt_ppg_addr_o = '0;
        if (cmd_i.addr_sel) begin
            tgt_ppg_addr_o[PPG_AW-1:0] = PPG_AW'(cmd_i.dst_row[PPG_AW-1:0] + ppg_step);
        end else begin
            tgt_cmp_addr_o[CMP_AW-1:0] = CMP_AW'(cmd_i.dst_row + cmp_step);
        end
    end

endmodule

// File: rtl/cam_subarray_seq.sv
// Sequencer driving one CAM subarray: writes, masked updates and search/update sweeps.
module cam_subarray_seq
    import cam_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    cam_subarray_seq_if.slave   bus,
    output logic                cam_ce,
    output logic [2:0]          cam_mode,
    output logic [DATA_W-1:0]   cam_data_in,
    output logic                cam_update_signal,
    output logic [2*CMP_AW-1:0] cam_cmp_addr,
    output logic [2*PPG_AW-1:0] cam_ppg_addr,
    output logic [1:0]          cam_cmp_data,
    output logic [1:0]          cam_ppg_data,
    output logic [DATA_W-1:0]   cam_tag_in,
    output logic                cam_addr_select,
    input  logic [DATA_W-1:0]   cam_tag_out
);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d, cmd_in;
    logic [LEN_W-1:0]  iter_q, iter_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_tag_q, rsp_tag_d;
    logic              rsp_err_q, rsp_err_d;
    cam_pins_t         pins_q, pins_d;
    logic              accept;

    logic [2*CMP_AW-1:0] sweep_cmp_addr, tgt_cmp_addr;
    logic [2*PPG_AW-1:0] sweep_ppg_addr, tgt_ppg_addr;

    assign bus.cmd_ready = (state_q == ST_IDLE) && !RST;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    assign cmd_in = '{op: bus.cmd_op, search_mode: bus.cmd_search_mode,
                      cmp_addr: bus.cmd_cmp_addr, ppg_addr: bus.cmd_ppg_addr,
                      cmp_data: bus.cmd_cmp_data, ppg_data: bus.cmd_ppg_data,
                      addr_sel: bus.cmd_addr_sel, dst_row: bus.cmd_dst_row,
                      wdata: bus.cmd_wdata, upd_val: bus.cmd_upd_val, len: bus.cmd_len};

    // Addresses follow the next state so the pin registers line up with state_q.
    cam_seq_addr_gen u_addr_gen (
        .cmd_i          (cmd_d),
        .iter_i         (iter_d),
        .cmp_addr_o     (sweep_cmp_addr),
        .ppg_addr_o     (sweep_ppg_addr),
        .tgt_cmp_addr_o (tgt_cmp_addr),
        .tgt_ppg_addr_o (tgt_ppg_addr)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            iter_q      <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
            pins_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            iter_q      <= iter_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
            pins_q      <= pins_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        iter_d      = iter_q;
        acc_d       = acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                cmd_d  = cmd_in;
                iter_d = '0;
                acc_d  = '0;
                case (cmd_in.op)
                    OP_WRITE:    state_d = ST_WR;
                    OP_MASK_UPD: state_d = ST_UPD;
                    default: begin
                        if (mode_legal(cmd_in.search_mode)) begin
                            state_d = ST_CMP;
                        end else begin
                            state_d     = ST_RSP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_tag_d   = '0;
                        end
                    end
                endcase
            end
            ST_WR: begin
                state_d     = ST_RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_tag_d   = '0;
            end
            ST_CMP: state_d = ST_CAP;
            ST_CAP: begin
                acc_d = acc_q | cam_tag_out;
                if (cmd_q.op == OP_SEARCH) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_tag_d   = acc_q | cam_tag_out;
                end else begin
                    state_d = ST_UPD;
                end
            end
            ST_UPD: begin
                if (cmd_q.op == OP_SRCH_UPD && iter_q != cmd_q.len) begin
                    iter_d  = iter_q + LEN_W'(1);
                    state_d = ST_CMP;
                end else begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_tag_d   = (cmd_q.op == OP_SRCH_UPD) ? acc_q : '0;
                end
            end
            ST_RSP: if (bus.rsp_ready) begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_tag_d   = '0;
                acc_d       = '0;
                iter_d      = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin image for the coming cycle; CAP/RSP/IDLE leave ce low so tag_out holds.
    always_comb begin
        pins_d = '0;
        case (state_d)
            ST_WR: begin
                pins_d.ce          = 1'b1;
                pins_d.mode        = MODE_WRITE;
                pins_d.data_in     = cmd_d.wdata;
                pins_d.addr_select = cmd_d.addr_sel;
                pins_d.cmp_addr    = tgt_cmp_addr;
                pins_d.ppg_addr    = tgt_ppg_addr;
            end
            ST_CMP: begin
                pins_d.ce       = 1'b1;
                pins_d.mode     = cmd_d.search_mode;
                pins_d.cmp_addr = sweep_cmp_addr;
                pins_d.ppg_addr = sweep_ppg_addr;
                pins_d.cmp_data = cmd_d.cmp_data;
                pins_d.ppg_data = cmd_d.ppg_data;
            end
            ST_UPD: begin
                pins_d.ce            = 1'b1;
                pins_d.mode          = MODE_UPD;
                pins_d.tag_in        = (cmd_d.op == OP_MASK_UPD) ? cmd_d.wdata : cam_tag_out;
                pins_d.update_signal = cmd_d.upd_val;
                pins_d.addr_select   = cmd_d.addr_sel;
                pins_d.cmp_addr      = tgt_cmp_addr;
                pins_d.ppg_addr      = tgt_ppg_addr;
            end
            default: ;
        endcase
    end

    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_tag       = rsp_tag_q;
    assign bus.rsp_err       = rsp_err_q;
    assign cam_ce            = pins_q.ce;
    assign cam_mode          = pins_q.mode;
    assign cam_data_in       = pins_q.data_in;
    assign cam_update_signal = pins_q.update_signal;
    assign cam_cmp_addr      = pins_q.cmp_addr;
    assign cam_ppg_addr      = pins_q.ppg_addr;
    assign cam_cmp_data      = pins_q.cmp_data;
    assign cam_ppg_data      = pins_q.ppg_data;
    assign cam_tag_in        = pins_q.tag_in;
    assign cam_addr_select   = pins_q.addr_select;

endmodule

// File: tb/tb_cam_subarray_seq.sv
// Scoreboard bench for cam_subarray_seq with a behavioural subarray model.
module tb_cam_subarray_seq;
    import cam_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    cam_subarray_seq_if bus ();

    logic                cam_ce, cam_update_signal, cam_addr_select;
    logic [2:0]          cam_mode;
    logic [DATA_W-1:0]   cam_data_in, cam_tag_in;
    logic [2*CMP_AW-1:0] cam_cmp_addr;
    logic [2*PPG_AW-1:0] cam_ppg_addr;
    logic [1:0]          cam_cmp_data, cam_ppg_data;
    logic [DATA_W-1:0]   cam_tag_out = '0;

    cam_subarray_seq dut (
        .CLK(CLK), .RST(RST), .bus(bus),
        .cam_ce(cam_ce), .cam_mode(cam_mode), .cam_data_in(cam_data_in),
        .cam_update_signal(cam_update_signal), .cam_cmp_addr(cam_cmp_addr),
        .cam_ppg_addr(cam_ppg_addr), .cam_cmp_data(cam_cmp_data),
        .cam_ppg_data(cam_ppg_data), .cam_tag_in(cam_tag_in),
        .cam_addr_select(cam_addr_select), .cam_tag_out(cam_tag_out)
    );

    // Subarray model: compare selects a row (or its complement when the search bit is 0).
    logic [DATA_W-1:0] cmp_mem [CMP_ROWS];
    logic [DATA_W-1:0] ppg_mem [PPG_ROWS];

    function automatic logic [DATA_W-1:0] hit(input logic [DATA_W-1:0] row, input logic b);
        return b ? row : ~row;
    endfunction

    always @(posedge CLK) begin
        if (cam_ce === 1'b1) begin
            case (cam_mode)
                MODE_WRITE:
                    if (cam_addr_select) ppg_mem[cam_ppg_addr[2:0]] <= cam_data_in;
                    else                 cmp_mem[cam_cmp_addr[4:0]] <= cam_data_in;
                MODE_UPD:
                    if (cam_addr_select)
                        ppg_mem[cam_ppg_addr[2:0]] <= (ppg_mem[cam_ppg_addr[2:0]] & ~cam_tag_in)
                                                      | (cam_tag_in & {DATA_W{cam_update_signal}});
                    else
                        cmp_mem[cam_cmp_addr[4:0]] <= (cmp_mem[cam_cmp_addr[4:0]] & ~cam_tag_in)
                                                      | (cam_tag_in & {DATA_W{cam_update_signal}});
                MODE_CMP1: cam_tag_out <= hit(cmp_mem[cam_cmp_addr[4:0]], cam_cmp_data[0]);
                MODE_CMP2: cam_tag_out <= hit(cmp_mem[cam_cmp_addr[4:0]], cam_cmp_data[0])
                                        & hit(cmp_mem[cam_cmp_addr[9:5]], cam_cmp_data[1]);
                MODE_PPG1: cam_tag_out <= hit(ppg_mem[cam_ppg_addr[2:0]], cam_ppg_data[0]);
                MODE_PPG2: cam_tag_out <= hit(ppg_mem[cam_ppg_addr[2:0]], cam_ppg_data[0])
                                        & hit(ppg_mem[cam_ppg_addr[5:3]], cam_ppg_data[1]);
                MODE_MIX:  cam_tag_out <= hit(cmp_mem[cam_cmp_addr[4:0]], cam_cmp_data[0])
                                        & hit(ppg_mem[cam_ppg_addr[2:0]], cam_ppg_data[0]);
                default: ;
            endcase
        end
    end

    typedef struct {
        string             name;
        logic [DATA_W-1:0] tag;
        logic              err;
        int                lat;
        int                ce_n;
        int                acc_cyc;
        int                ce0;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ce_total = 0;
    int   last_acc = 0;
    bit   prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: pops one expectation at the first cycle each response is presented.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (cam_ce === 1'b1) ce_total++;
        if (bus.rsp_valid === 1'b1 && !prev_valid) begin
            chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({e.name, "_tag"}, 64'(bus.rsp_tag), 64'(e.tag));
                chk({e.name, "_err"}, 64'(bus.rsp_err), 64'(e.err));
                chk({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
                chk({e.name, "_ce_cycles"}, 64'(ce_total - e.ce0), 64'(e.ce_n));
            end
        end
        prev_valid = (bus.rsp_valid === 1'b1);
    end

    function automatic cmd_t mk(input logic [1:0] op, input logic [2:0] mode,
                                input logic [9:0] ca, input logic [5:0] pa,
                                input logic [1:0] cd, input logic [1:0] pd,
                                input logic sel, input logic [4:0] dst,
                                input logic [31:0] wd, input logic upd, input logic [4:0] len);
        cmd_t c;
        c.op = op; c.search_mode = mode; c.cmp_addr = ca; c.ppg_addr = pa;
        c.cmp_data = cd; c.ppg_data = pd; c.addr_sel = sel; c.dst_row = dst;
        c.wdata = wd; c.upd_val = upd; c.len = len;
        return c;
    endfunction

    task automatic send(input string name, input cmd_t c, input bit track,
                        input logic [31:0] etag, input logic eerr, input int elat, input int ece);
        int   n;
        exp_t e;
        @(negedge CLK);
        bus.cmd_op = c.op;             bus.cmd_search_mode = c.search_mode;
        bus.cmd_cmp_addr = c.cmp_addr; bus.cmd_ppg_addr = c.ppg_addr;
        bus.cmd_cmp_data = c.cmp_data; bus.cmd_ppg_data = c.ppg_data;
        bus.cmd_addr_sel = c.addr_sel; bus.cmd_dst_row = c.dst_row;
        bus.cmd_wdata = c.wdata;       bus.cmd_upd_val = c.upd_val;
        bus.cmd_len = c.len;           bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk({name, "_accepted"}, 64'(n < 100), 64'd1);
        if (track) begin
            e.name = name; e.tag = etag; e.err = eerr; e.lat = elat; e.ce_n = ece;
            e.acc_cyc = cyc; e.ce0 = ce_total;
            exp_q.push_back(e);
        end
        last_acc = cyc;
        @(posedge CLK);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge CLK);
        while ((exp_q.size() != 0 || bus.rsp_valid !== 1'b0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk({name, "_drained"}, 64'(n < 200), 64'd1);
    endtask

    task automatic run(input string name, input cmd_t c, input logic [31:0] etag,
                       input logic eerr, input int elat, input int ece);
        send(name, c, 1'b1, etag, eerr, elat, ece);
        wait_done(name);
    endtask

    function automatic cmd_t srch(input logic [2:0] mode, input logic [9:0] ca,
                                  input logic [5:0] pa, input logic [1:0] cd, input logic [1:0] pd);
        return mk(OP_SEARCH, mode, ca, pa, cd, pd, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endfunction

    function automatic cmd_t wr(input logic sel, input logic [4:0] dst, input logic [31:0] wd);
        return mk(OP_WRITE, 3'd0, 10'd0, 6'd0, 2'd0, 2'd0, sel, dst, wd, 1'b0, 5'd0);
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        for (int i = 0; i < int'(CMP_ROWS); i++) cmp_mem[i] = '0;
        for (int i = 0; i < int'(PPG_ROWS); i++) ppg_mem[i] = '0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_search_mode = '0;
        bus.cmd_cmp_addr = '0; bus.cmd_ppg_addr = '0; bus.cmd_cmp_data = '0;
        bus.cmd_ppg_data = '0; bus.cmd_addr_sel = 1'b0; bus.cmd_dst_row = '0;
        bus.cmd_wdata = '0; bus.cmd_upd_val = 1'b0; bus.cmd_len = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge CLK);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_pins", 64'(|{cam_ce, cam_mode, cam_data_in, cam_update_signal, cam_cmp_addr,
                              cam_ppg_addr, cam_cmp_data, cam_ppg_data, cam_tag_in,
                              cam_addr_select}), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        run("wr_r5",    wr(1'b0, 5'd5, 32'hA5A5_0F0F), 32'h0, 1'b0, 2, 1);
        run("srch_r5",  srch(MODE_CMP1, 10'd5, 6'd0, 2'b01, 2'b00), 32'hA5A5_0F0F, 1'b0, 3, 1);
        run("mupd_r5",  mk(OP_MASK_UPD, 3'd0, 10'd0, 6'd0, 2'd0, 2'd0, 1'b0, 5'd5,
                           32'h0000_00FF, 1'b0, 5'd0), 32'h0, 1'b0, 2, 1);
        run("srch_r5b", srch(MODE_CMP1, 10'd5, 6'd0, 2'b01, 2'b00), 32'hA5A5_0F00, 1'b0, 3, 1);

        run("wr_r30", wr(1'b0, 5'd30, 32'h1), 32'h0, 1'b0, 2, 1);
        run("wr_r31", wr(1'b0, 5'd31, 32'h2), 32'h0, 1'b0, 2, 1);
        run("wr_r0",  wr(1'b0, 5'd0,  32'h4), 32'h0, 1'b0, 2, 1);
        run("sweep3", mk(OP_SRCH_UPD, MODE_CMP1, 10'd30, 6'd0, 2'b01, 2'b00, 1'b0, 5'd3,
                         32'd0, 1'b1, 5'd2), 32'h7, 1'b0, 10, 6);
        run("srch_r3",   srch(MODE_CMP1, 10'd3, 6'd0, 2'b01, 2'b00), 32'h1, 1'b0, 3, 1);
        run("srch_r4",   srch(MODE_CMP1, 10'd4, 6'd0, 2'b01, 2'b00), 32'h2, 1'b0, 3, 1);
        run("srch_r5c",  srch(MODE_CMP1, 10'd5, 6'd0, 2'b01, 2'b00), 32'hA5A5_0F04, 1'b0, 3, 1);
        run("srch_r4n",  srch(MODE_CMP1, 10'd4, 6'd0, 2'b00, 2'b00), 32'hFFFF_FFFD, 1'b0, 3, 1);
        run("srch_cmp2", srch(MODE_CMP2, {5'd31, 5'd30}, 6'd0, 2'b01, 2'b00), 32'h1, 1'b0, 3, 1);

        run("bad_111", srch(3'b111, 10'd5, 6'd0, 2'b01, 2'b00), 32'h0, 1'b1, 1, 0);
        run("bad_001", srch(3'b001, 10'd5, 6'd0, 2'b01, 2'b00), 32'h0, 1'b1, 1, 0);
        run("bad_su000", mk(OP_SRCH_UPD, 3'b000, 10'd30, 6'd0, 2'b01, 2'b00, 1'b0, 5'd3,
                            32'd0, 1'b1, 5'd2), 32'h0, 1'b1, 1, 0);

        run("wr_p2",    wr(1'b1, 5'd2, 32'h1234_5678), 32'h0, 1'b0, 2, 1);
        run("srch_p2",  srch(MODE_PPG1, 10'd0, 6'd2, 2'b00, 2'b01), 32'h1234_5678, 1'b0, 3, 1);
        run("sweep_p",  mk(OP_SRCH_UPD, MODE_PPG1, 10'd0, 6'd2, 2'b00, 2'b01, 1'b1, 5'd7,
                           32'd0, 1'b1, 5'd1), 32'h1234_5678, 1'b0, 7, 4);
        run("srch_p7",  srch(MODE_PPG1, 10'd0, 6'd7, 2'b00, 2'b01), 32'h1234_5678, 1'b0, 3, 1);
        run("srch_mix", srch(MODE_MIX, 10'd5, 6'd7, 2'b01, 2'b01), 32'h0024_0600, 1'b0, 3, 1);

        // Back-pressure: response must hold while rsp_ready is low.
        bus.rsp_ready = 1'b0;
        send("stall", srch(MODE_CMP1, 10'd5, 6'd0, 2'b01, 2'b00), 1'b1, 32'hA5A5_0F04, 1'b0, 3, 1);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("stall_rsp_seen", 64'(n < 20), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("stall_valid", 64'(bus.rsp_valid), 64'd1);
            chk("stall_tag", 64'(bus.rsp_tag), 64'hA5A5_0F04);
            chk("stall_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        wait_done("stall");

        // Reset in the update of iteration 1 of a four-iteration sweep.
        send("rst_sweep", mk(OP_SRCH_UPD, MODE_CMP1, 10'd30, 6'd0, 2'b01, 2'b00, 1'b0, 5'd10,
                             32'd0, 1'b1, 5'd3), 1'b0, 32'h0, 1'b0, 0, 0);
        n = 0;
        while (cyc != last_acc + 6 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("rst_sweep_reached", 64'(n < 50), 64'd1);
        chk("upd1_ce", 64'(cam_ce), 64'd1);
        chk("upd1_mode", 64'(cam_mode), 64'(MODE_UPD));
        chk("upd1_addr", 64'(cam_cmp_addr), 64'd11);
        chk("upd1_tag_in", 64'(cam_tag_in), 64'h2);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_pins", 64'(|{cam_ce, cam_mode, cam_data_in, cam_update_signal, cam_cmp_addr,
                                 cam_ppg_addr, cam_cmp_data, cam_ppg_data, cam_tag_in,
                                 cam_addr_select}), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("postrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        run("post_r10", srch(MODE_CMP1, 10'd10, 6'd0, 2'b01, 2'b00), 32'h1, 1'b0, 3, 1);
        run("post_r12", srch(MODE_CMP1, 10'd12, 6'd0, 2'b01, 2'b00), 32'h0, 1'b0, 3, 1);
        run("post_r30", srch(MODE_CMP1, 10'd30, 6'd0, 2'b01, 2'b00), 32'h1, 1'b0, 3, 1);

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_subarray_seq.md
Name: cam_subarray_seq

Overview:
- Command sequencer in front of one CAM subarray (32 cmp rows + 8 ppg rows, 32-bit wide, tag_out registered one cycle after a compare).
- Accepts commands over a valid/ready interface and drives the subarray's chip_enable, operation_mode, address, data, tag_in and update_signal pins cycle by cycle.
- Executes search-then-masked-update (associative write) sweeps and returns the accumulated match tag over a valid/ready response interface.
- Only master of the subarray; sits between the array-level scheduler and the CAM.

Parameters:
DATA_W, 32, row/tag width; must equal the subarray word width
LEN_W, 5, width of sweep length field; a sweep runs 1 to 2^LEN_W iterations

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when valid&ready
cmd_op  input  2  0 WRITE, 1 SEARCH, 2 SRCH_UPD, 3 MASK_UPD
cmd_search_mode  input  3  subarray compare mode; legal 3'b010..3'b110
cmd_cmp_addr  input  10  cmp row pair {hi[9:5], lo[4:0]}
cmd_ppg_addr  input  6  ppg row pair {hi[5:3], lo[2:0]}
cmd_cmp_data  input  2  search bits for cmp rows
cmd_ppg_data  input  2  search bits for ppg rows
cmd_addr_sel  input  1  write/update target region: 0 cmp row, 1 ppg row
cmd_dst_row  input  5  write/update target row (ppg uses [2:0])
cmd_wdata  input  DATA_W  WRITE data, or MASK_UPD mask
cmd_upd_val  input  1  value written under mask
cmd_len  input  LEN_W  sweep iterations minus 1 (SRCH_UPD only)
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when valid&ready
rsp_tag  output  DATA_W  OR of all captured tags; 0 for WRITE/MASK_UPD
rsp_err  output  1  illegal search mode; no CAM access performed
cam_ce, cam_mode[2:0], cam_data_in[DATA_W], cam_update_signal, cam_cmp_addr[10], cam_ppg_addr[6], cam_cmp_data[2], cam_ppg_data[2], cam_tag_in[DATA_W], cam_addr_select  outputs  to subarray pins of the same meaning
cam_tag_out  input  DATA_W  subarray tag_out

Behaviour:
- Clock CLK, synchronous active-high reset RST. Reset dominates every cycle, including mid-sweep: state IDLE; iteration counter 0; tag accumulator 0; rsp_valid 0, rsp_err 0, rsp_tag 0; cam_ce 0, all other cam_* outputs 0. A half-finished sweep is abandoned; rows already written stay written.
- States: IDLE, WR, CMP, CAP, UPD, RSP.
- cmd_ready = (state==IDLE) & !RST. Command fields are latched on acceptance; no pipelining, one command in flight.
- cam_ce is 1 only in WR, CMP and UPD. It is 0 in IDLE, CAP and RSP, so the subarray's tag_out holds its value.
- WRITE: IDLE->WR. WR drives mode 000, cam_data_in=wdata, target row. WR->RSP.
- MASK_UPD: IDLE->UPD. UPD drives mode 001, cam_tag_in=wdata, cam_update_signal=upd_val. UPD->RSP.
- SEARCH / SRCH_UPD with an illegal mode (000, 001, 111): IDLE->RSP with rsp_err=1 and rsp_tag=0.
- SEARCH: IDLE->CMP. CMP drives mode=search_mode with the iteration's addresses and data. CMP->CAP. CAP registers cam_tag_out into the accumulator (OR). CAP->RSP.
- SRCH_UPD: CMP->CAP->UPD. UPD drives mode 001 to the target row, cam_tag_in = tag captured this iteration (not the accumulated tag), cam_update_signal=upd_val. Then:
  - if iter==len: UPD->RSP;
  - else iter+=1 and UPD->CMP.
- Iteration addressing, with i = iter:
  - cmp lo = lo+i, cmp hi = hi+i (each mod 32);
  - ppg lo = lo+i, ppg hi = hi+i (each mod 8);
  - target row = dst+i (mod 32, or mod 8 for ppg).
  - All additions wrap silently; no carry between fields.
- Target address routing: cam_addr_select=cmd_addr_sel in WR and UPD. The target drives cam_cmp_addr[4:0] or cam_ppg_addr[2:0]; the unused address bits are 0. In CMP, cam_addr_select=0.
- Latency, counting the acceptance edge as cycle 0, with rsp_valid first high in cycle N:
  - WRITE, MASK_UPD: N=2;
  - SEARCH: N=3;
  - SRCH_UPD: N=1+3*(len+1).
- RSP holds rsp_valid, rsp_tag and rsp_err stable until rsp_ready. Then ->IDLE: accumulator and iter clear, rsp_valid drops next cycle. A new command is accepted one cycle after that, at the earliest.

Decomposition:
- Shared package cam_pkg holds:
  - op encodings;
  - CAM mode constants MODE_WRITE=000, MODE_UPD=001, MODE_CMP1=010, MODE_PPG1=011, MODE_CMP2=100, MODE_PPG2=101, MODE_MIX=110;
  - the state enum;
  - CMP_ROWS=32, PPG_ROWS=8.
- One natural sub-module, cam_seq_addr_gen: combinational per-iteration address/target computation from latched fields and iter.

Test Plan:
- WRITE row 5 wdata 0xA5A5_0F0F; then SEARCH mode 010, cmp_addr lo=5, cmp_data=1 -> first rsp_tag 0, rsp_valid at cycle 2; second rsp_tag 0xA5A5_0F0F, rsp_valid at cycle 3.
- MASK_UPD row 5, mask 0x0000_00FF, upd_val 0 -> SEARCH as above returns 0xA5A5_0F00.
- SRCH_UPD len=2, mode 010, cmp lo=30, data=1, dst=3, upd_val=1; rows 30, 31, 0 = 0x1, 0x2, 0x4 -> rows 3, 4, 5 gain bits 0x1, 0x2, 0x4; rsp_tag 0x7 at cycle 10; cam_ce never high in CAP.
- cmd_search_mode 111 -> rsp_err=1, rsp_tag=0, cam_ce stays 0, rsp_valid at cycle 1.
- Hold rsp_ready=0 for 5 cycles -> rsp_tag and rsp_valid stable; cmd_ready=0 throughout.
- Assert RST during UPD of iteration 1 of a len=3 sweep -> next cycle state IDLE, all outputs 0; a fresh SEARCH returns a correct tag.
